counter_seq_ctrl: RTL and testbench

COUNTER_SEQ_CTRL -- requirements
Module: counter_seq_ctrl

---
 rtl/counter_ctrl_pkg.sv | 32 +++
 rtl/tick_gen.sv | 29 ++
 rtl/counter_seq_ctrl.sv | 121 ++++++++++++
 tb/tb_counter_seq_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared state encodings, default widths and command decode for the counter sequencer.
package counter_ctrl_pkg;

   localparam int unsigned DEF_DIV_W = 26;
   localparam int unsigned DEF_DIV_M = 50_000_000;
   localparam int unsigned DEF_CNT_W = 4;
   localparam int unsigned STATE_W   = 2;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   typedef struct packed {
      logic stop;
      logic pause;
      logic start;
      logic load;
   } cmd_t;

   // At most one field is set: stop > pause > start > load.
   function automatic cmd_t decode_cmd(input logic stop, input logic pause,
                                       input logic start, input logic load);
      cmd_t c;
      c.stop  = stop;
      c.pause = !stop && pause;
      c.start = !stop && !pause && start;
      c.load  = !stop && !pause && !start && load;
      return c;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts 0..DIV_M-1 while enabled and flags the last cycle of each period.
module tick_gen
   import counter_ctrl_pkg::*;
#(
   parameter int unsigned DIV_W = DEF_DIV_W,
   parameter int unsigned DIV_M = DEF_DIV_M
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam logic [DIV_W-1:0] TERM = DIV_W'(DIV_M - 1);

   logic [DIV_W-1:0] div_cnt;

   assign tick = en && (div_cnt == TERM);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         div_cnt <= '0;
      end else if (en) begin
         div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Start/stop/pause controlled up/down counter stepping once every DIV_M clocks.
module counter_seq_ctrl
   import counter_ctrl_pkg::*;
#(
   parameter int unsigned DIV_W = DEF_DIV_W,
   parameter int unsigned DIV_M = DEF_DIV_M,
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               stop,
   input  logic               pause,
   input  logic               up_dn,
   input  logic               mode,
   input  logic               load,
   input  logic [CNT_W-1:0]   load_val,
   input  logic [CNT_W-1:0]   limit,
   output logic [CNT_W-1:0]   count,
   output logic               tick,
   output logic               done,
   output logic               busy,
   output logic [STATE_W-1:0] state
);

   cmd_t               cmd;
   logic               pre_en;
   logic               pre_clr;
   logic               pre_tick;
   logic               terminal;
   logic [STATE_W-1:0] state_nxt;
   logic [CNT_W-1:0]   count_nxt;
   logic               tick_nxt;
   logic               done_nxt;

   always_comb cmd = decode_cmd(stop, pause, start, load);

   // A stop or pause in the step cycle freezes the prescaler, which also swallows the tick.
   assign pre_en   = (state == ST_RUN) && !stop && !pause;
   assign pre_clr  = cmd.stop || (cmd.start && ((state == ST_IDLE) || (state == ST_DONE)));
   assign terminal = up_dn ? (count == limit) : (count == '0);

   tick_gen #(
      .DIV_W (DIV_W),
      .DIV_M (DIV_M)
   ) u_tick_gen (
      .clk   (clk),
      .reset (reset),
      .en    (pre_en),
      .clr   (pre_clr),
      .tick  (pre_tick)
   );

   always_comb begin
      state_nxt = state;
      count_nxt = count;
      tick_nxt  = 1'b0;
      done_nxt  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (cmd.start) begin
               state_nxt = ST_RUN;
            end else if (cmd.load) begin
               count_nxt = load_val;
            end
         end
         ST_RUN: begin
            if (cmd.stop) begin
               state_nxt = ST_IDLE;
            end else if (cmd.pause) begin
               state_nxt = ST_PAUSE;
            end else if (pre_tick) begin
               tick_nxt = 1'b1;
               if (terminal && !mode) begin
                  state_nxt = ST_DONE;
                  done_nxt  = 1'b1;
               end else if (terminal) begin
                  count_nxt = up_dn ? '0 : limit;
               end else begin
                  count_nxt = up_dn ? count + CNT_W'(1) : count - CNT_W'(1);
               end
            end
         end
         ST_PAUSE: begin
            if (cmd.stop) begin
               state_nxt = ST_IDLE;
            end else if (cmd.pause) begin
               state_nxt = ST_RUN;
            end
         end
         ST_DONE: begin
            if (cmd.stop) begin
               state_nxt = ST_IDLE;
            end else if (cmd.start) begin
               state_nxt = ST_RUN;
               count_nxt = up_dn ? '0 : limit;
            end else if (cmd.load) begin
               count_nxt = load_val;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         count <= '0;
         tick  <= 1'b0;
         done  <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
         tick  <= tick_nxt;
         done  <= done_nxt;
         busy  <= (state_nxt == ST_RUN) || (state_nxt == ST_PAUSE);
      end
   end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Randomized bench for counter_seq_ctrl against a cycle-level reference model of the rules.
module tb_counter_seq_ctrl;

   localparam int unsigned DIV_W = 3;
   localparam int unsigned DIV_M = 4;
   localparam int unsigned CNT_W = 4;
   localparam int          MOD   = 16;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             start = 1'b0;
   logic             stop = 1'b0;
   logic             pause = 1'b0;
   logic             up_dn = 1'b1;
   logic             mode = 1'b1;
   logic             load = 1'b0;
   logic [CNT_W-1:0] load_val = '0;
   logic [CNT_W-1:0] limit = '0;
   logic [CNT_W-1:0] count;
   logic             tick;
   logic             done;
   logic             busy;
   logic [1:0]       state;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: state as 0..3, run_cycles = RUN cycles spent in the current step.
   int m_state = 0;
   int m_count = 0;
   int run_cycles = 0;
   bit m_tick = 0;
   bit m_done = 0;

   bit cur_ud = 1;
   bit cur_md = 1;
   int cur_lim = 3;

   always #5 clk = ~clk;

   counter_seq_ctrl #(
      .DIV_W (DIV_W),
      .DIV_M (DIV_M),
      .CNT_W (CNT_W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .stop     (stop),
      .pause    (pause),
      .up_dn    (up_dn),
      .mode     (mode),
      .load     (load),
      .load_val (load_val),
      .limit    (limit),
      .count    (count),
      .tick     (tick),
      .done     (done),
      .busy     (busy),
      .state    (state)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_update(input bit r, input bit st, input bit sp, input bit pa,
                               input bit ld, input int lv);
      int c;
      bit hit_end;
      if (r) begin
         m_state = 0; m_count = 0; run_cycles = 0; m_tick = 0; m_done = 0;
         return;
      end
      c = sp ? 1 : pa ? 2 : st ? 3 : ld ? 4 : 0;
      m_tick = 0;
      m_done = 0;
      case (m_state)
         0: begin
            if (c == 1) run_cycles = 0;
            else if (c == 3) begin m_state = 1; run_cycles = 0; end
            else if (c == 4) m_count = lv;
         end
         1: begin
            if (c == 1) begin m_state = 0; run_cycles = 0; end
            else if (c == 2) m_state = 2;
            else begin
               run_cycles++;
               if (run_cycles == DIV_M) begin
                  run_cycles = 0;
                  m_tick = 1;
                  hit_end = cur_ud ? (m_count == cur_lim) : (m_count == 0);
                  if (hit_end && cur_md) m_count = cur_ud ? 0 : cur_lim;
                  else if (hit_end) begin m_state = 3; m_done = 1; end
                  else m_count = (m_count + (cur_ud ? 1 : MOD - 1)) % MOD;
               end
            end
         end
         2: begin
            if (c == 1) begin m_state = 0; run_cycles = 0; end
            else if (c == 2) m_state = 1;
         end
         default: begin
            if (c == 1) begin m_state = 0; run_cycles = 0; end
            else if (c == 3) begin m_state = 1; run_cycles = 0; m_count = cur_ud ? 0 : cur_lim; end
            else if (c == 4) m_count = lv;
         end
      endcase
   endtask

   // One clock: drive at the falling edge, compare after the following falling edge.
   task automatic step(input bit r, input bit st, input bit sp, input bit pa,
                       input bit ld, input int lv);
      reset    = r;
      start    = st;
      stop     = sp;
      pause    = pa;
      load     = ld;
      load_val = CNT_W'(lv);
      up_dn    = cur_ud;
      mode     = cur_md;
      limit    = CNT_W'(cur_lim);
      model_update(r, st, sp, pa, ld, lv);
      @(posedge clk);
      @(negedge clk);
      check_eq("count", 32'(count), 32'(m_count));
      check_eq("state", 32'(state), 32'(m_state));
      check_eq("tick", 32'(tick), 32'(m_tick));
      check_eq("done", 32'(done), 32'(m_done));
      check_eq("busy", 32'(busy), 32'((m_state == 1) || (m_state == 2)));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      int ticks_seen;
      @(negedge clk);
      step(1, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 1, 9);
      check_eq("reset_count", 32'(count), 32'd0);

      // Continuous up count with limit 3
      cur_ud = 1; cur_md = 1; cur_lim = 3;
      step(0, 1, 0, 0, 0, 0);
      ticks_seen = 0;
      for (int i = 0; i < 20; i++) begin
         step(0, 0, 0, 0, 0, 0);
         if (tick) ticks_seen++;
      end
      check_eq("wrap_up_count", 32'(count), 32'd1);
      check_eq("wrap_up_ticks", 32'(ticks_seen), 32'd5);

      // Load 5, one-shot down count to 0
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 1, 5);
      cur_ud = 0; cur_md = 0;
      step(0, 1, 0, 0, 0, 0);
      idle(30);
      check_eq("oneshot_state", 32'(state), 32'd3);
      check_eq("oneshot_count", 32'(count), 32'd0);

      // Start and stop together in IDLE
      step(0, 0, 1, 0, 0, 0);
      step(0, 1, 1, 0, 0, 0);
      check_eq("start_stop_idle", 32'(state), 32'd0);

      // Count above limit wraps through 15 before reaching limit 2
      cur_ud = 1; cur_md = 1; cur_lim = 2;
      step(0, 0, 0, 0, 1, 7);
      step(0, 1, 0, 0, 0, 0);
      idle(44);
      check_eq("above_limit_at2", 32'(count), 32'd2);
      idle(4);
      check_eq("above_limit_wrap", 32'(count), 32'd0);

      // Pause two cycles after a tick, hold 10 cycles, resume
      idle(1);
      step(0, 0, 0, 1, 0, 0);
      idle(10);
      step(0, 0, 0, 1, 0, 0);
      idle(3);
      step(1, 0, 0, 0, 0, 0);

      // Randomized traffic
      for (int i = 0; i < 5000; i++) begin
         bit r, st, sp, pa, ld;
         if ($urandom_range(15) == 0) cur_ud = 1'($urandom_range(1));
         if ($urandom_range(15) == 0) cur_md = 1'($urandom_range(1));
         if ($urandom_range(49) == 0) cur_lim = int'($urandom_range(MOD - 1));
         r  = ($urandom_range(299) == 0);
         sp = ($urandom_range(39) == 0);
         pa = ($urandom_range(29) == 0);
         st = ($urandom_range(7) == 0);
         ld = ($urandom_range(9) == 0);
         step(r, st, sp, pa, ld, int'($urandom_range(MOD - 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
